// File: rtl/map_loader.sv
// Loads one 8x8 maze (8 row words, start word, end word) from the banked map ROM into registers.
// Optional build macro MAP_CHECK_EN adds a start/end sanity check on the finished map.
module map_loader #(
  parameter int ROM_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [1:0]  map_sel,
  output logic [1:0]  rom_sel,
  output logic [3:0]  rom_addr,
  input  logic [7:0]  rom_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        map_valid,
  output logic [63:0] map_rows,
  output logic [5:0]  start_pos,
  output logic [5:0]  end_pos
);

  localparam int          CW        = $clog2(ROM_LAT + 11);
  localparam logic [3:0]  LAST_ADDR = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [CW-1:0] r_cyc;
  logic [1:0]    r_rom_sel;
  logic [3:0]    r_rom_addr;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic          r_valid;
  logic [63:0]   r_rows;
  logic [5:0]    r_start;
  logic [5:0]    r_end;

  // r_cyc counts FETCH cycles from the first address; the word on rom_data
  // belongs to the address issued ROM_LAT cycles earlier.
  logic          w_cap;
  logic [CW-1:0] w_k;
  logic          w_ok;

  assign w_cap = (r_cyc >= CW'(ROM_LAT));
  assign w_k   = r_cyc - CW'(ROM_LAT);

`ifdef MAP_CHECK_EN
  // Evaluated on the cycle word 9 arrives, so the end point comes straight from rom_data.
  logic [5:0] w_end;
  assign w_end = rom_data[5:0];
  assign w_ok  = r_rows[r_start] & r_rows[w_end] & (r_start != w_end);
`else
  assign w_ok  = 1'b1;
`endif

  // NOTE: all state here is edge-triggered, so every assignment is non-blocking (<=);
  // blocking assignments would let later statements see same-cycle values and break the pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cyc      <= '0;
      r_rom_sel  <= '0;
      r_rom_addr <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_valid    <= 1'b0;
      r_rows     <= '0;
      r_start    <= '0;
      r_end      <= '0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (load) begin
            if (map_sel != 2'd3) begin
              r_rom_sel  <= map_sel;
              r_rom_addr <= '0;
              r_cyc      <= '0;
              r_busy     <= 1'b1;
              r_valid    <= 1'b0;
              r_state    <= S_FETCH;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        S_FETCH: begin
          r_cyc <= r_cyc + CW'(1);
          if (r_rom_addr != LAST_ADDR) begin
            r_rom_addr <= r_rom_addr + 4'd1;
          end
          if (w_cap) begin
            if (w_k < CW'(8)) begin
              r_rows[{w_k[2:0], 3'b000} +: 8] <= rom_data;
            end else if (w_k == CW'(8)) begin
              r_start <= rom_data[5:0];
            end else begin
              r_end   <= rom_data[5:0];
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_valid <= w_ok;
              r_err   <= ~w_ok;
              r_state <= S_DONE;
            end
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign rom_sel   = r_rom_sel;
  assign rom_addr  = r_rom_addr;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;
  assign map_valid = r_valid;
  assign map_rows  = r_rows;
  assign start_pos = r_start;
  assign end_pos   = r_end;

endmodule

// File: tb/tb_map_loader.sv
// Self-checking bench for map_loader: 2-cycle ROM model, timeline-based reference model, directed loads.
// Build with MAP_CHECK_EN defined to exercise the map sanity check.
module tb_map_loader;

`ifdef MAP_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [1:0]  map_sel = 2'd0;
  logic [1:0]  rom_sel;
  logic [3:0]  rom_addr;
  logic [7:0]  rom_data;
  logic        busy, done, err, map_valid;
  logic [63:0] map_rows;
  logic [5:0]  start_pos, end_pos;

  map_loader #(.ROM_LAT(2)) dut (
    .clk(clk), .rst(rst), .load(load), .map_sel(map_sel),
    .rom_sel(rom_sel), .rom_addr(rom_addr), .rom_data(rom_data),
    .busy(busy), .done(done), .err(err), .map_valid(map_valid),
    .map_rows(map_rows), .start_pos(start_pos), .end_pos(end_pos)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- ROM model: 3 banks x 10 words, two register stages ----------------
  logic [7:0] rom [3][10];
  logic [7:0] rom_s1;

  initial begin
    for (int r = 0; r < 8; r++) begin
      rom[0][r] = 8'hFF;
      rom[1][r] = 8'hFF << r;
      rom[2][r] = 8'h5A;
    end
    rom[0][8] = 8'o01;  rom[0][9] = 8'o76;
    rom[1][8] = 8'hC0;  rom[1][9] = 8'h3F;
    rom[2][2] = 8'h00;  rom[2][4] = 8'hFF;
    rom[2][8] = 8'o23;  rom[2][9] = 8'o45;
  end

  function automatic logic [7:0] rom_word(input logic [1:0] b, input logic [3:0] a);
    if (b == 2'd3 || a > 4'd9) return 8'hEE;
    return rom[b][a];
  endfunction

  always @(posedge clk) begin
    rom_s1   <= rom_word(rom_sel, rom_addr);
    rom_data <= rom_s1;
  end

  // ---------------- reference model ----------------
  function automatic logic [63:0] bank_rows(input logic [1:0] b);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[8*i +: 8] = rom[b][i];
    return v;
  endfunction

  function automatic logic map_ok(input logic [1:0] b);
    logic [63:0] rows;
    logic [5:0]  s, e;
    rows = bank_rows(b);
    s = rom[b][8][5:0];
    e = rom[b][9][5:0];
    if (!CHECK_EN) return 1'b1;
    return rows[s] && rows[e] && (s != e);
  endfunction

  // A load accepted at cycle T is busy for T+1..T+12 and done at T+13.
  int          t_start = -1000;
  logic [1:0]  m_sel = '0;
  logic [3:0]  m_addr = '0;
  logic        m_valid = 1'b0;
  logic        m_err = 1'b0;
  logic [63:0] m_rows = '0;
  logic [5:0]  m_start = '0, m_end = '0;
  int          done_cnt = 0;
  int          d;
  logic        e_busy, e_done, e_err, e_valid;
  logic [3:0]  e_addr;

  always @(negedge clk) begin
    cyc++;
    d = cyc - t_start;
    if (d >= 1 && d <= 12) begin
      e_busy = 1'b1; e_done = 1'b0; e_err = 1'b0; e_valid = 1'b0;
      e_addr = (d - 1 > 9) ? 4'd9 : 4'(d - 1);
    end else if (d == 13) begin
      e_busy = 1'b0; e_done = 1'b1; e_valid = m_valid;
      e_err = CHECK_EN && !m_valid; e_addr = 4'd9;
    end else begin
      e_busy = 1'b0; e_done = 1'b0; e_err = m_err; e_valid = m_valid; e_addr = m_addr;
    end
    check("busy", busy, e_busy);
    check("done", done, e_done);
    check("err", err, e_err);
    check("map_valid", map_valid, e_valid);
    check("rom_sel", rom_sel, m_sel);
    check("rom_addr", rom_addr, e_addr);
    if (!e_busy) begin
      check("map_rows", map_rows, m_rows);
      check("start_pos", start_pos, m_start);
      check("end_pos", end_pos, m_end);
    end
    if (done === 1'b1) done_cnt++;

    m_err = 1'b0;
    if (rst) begin
      t_start = -1000; m_sel = '0; m_addr = '0; m_valid = 1'b0;
      m_rows = '0; m_start = '0; m_end = '0;
    end else if (d >= 1 && d <= 12) begin
      if (d == 12) begin
        m_rows  = bank_rows(m_sel);
        m_start = rom[m_sel][8][5:0];
        m_end   = rom[m_sel][9][5:0];
        m_valid = map_ok(m_sel);
        m_addr  = 4'd9;
      end
    end else if (d != 13 && load) begin
      if (map_sel != 2'd3) begin
        t_start = cyc;
        m_sel   = map_sel;
        m_valid = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end
  end

  // ---------------- directed stimulus with literal expectations ----------------
  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  int dc0;

  initial begin
    // 1: reset
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    #1;
    check("t1 busy", busy, 0);
    check("t1 map_valid", map_valid, 0);
    check("t1 map_rows", map_rows, 64'h0);
    check("t1 rom_addr", rom_addr, 0);

    // 2: load bank 1
    load = 1'b1; map_sel = 2'd1;          // cycle T
    tick(1); load = 1'b0;                 // T+1
    check("t2 rom_sel", rom_sel, 1);
    check("t2 first addr", rom_addr, 0);
    check("t2 busy", busy, 1);
    tick(9);                              // T+10
    check("t2 last addr", rom_addr, 9);
    tick(3);                              // T+13
    check("t2 done at T+13", done, 1);
    check("t2 map_rows", map_rows, 64'h80C0E0F0F8FCFEFF);
    check("t2 start_pos", start_pos, 6'o00);
    check("t2 end_pos", end_pos, 6'o77);
    check("t2 map_valid", map_valid, 1);

    // 3: illegal select
    tick(1);
    load = 1'b1; map_sel = 2'd3;
    tick(1); load = 1'b0;
    check("t3 err", err, 1);
    check("t3 busy", busy, 0);
    check("t3 rom_addr held", rom_addr, 9);
    check("t3 map_valid kept", map_valid, 1);
    tick(1);
    check("t3 err one cycle", err, 0);

    // 4a: extra load mid-fetch is ignored
    dc0 = done_cnt;
    load = 1'b1; map_sel = 2'd0;          // T
    tick(1); load = 1'b0;
    tick(4);                              // T+5
    load = 1'b1; map_sel = 2'd2;
    tick(1); load = 1'b0; map_sel = 2'd0; // T+6
    tick(7);                              // T+13
    check("t4 done", done, 1);
    check("t4 rom_sel", rom_sel, 0);
    tick(16);
    check("t4 single done", done_cnt - dc0, 1);

    // 4b: reset mid-load
    load = 1'b1; map_sel = 2'd1;          // T
    tick(1); load = 1'b0;
    tick(5);                              // T+6
    rst = 1'b1;
    tick(1); rst = 1'b0;                  // T+7
    check("t4 rst busy", busy, 0);
    check("t4 rst map_valid", map_valid, 0);
    check("t4 rst rom_addr", rom_addr, 0);
    check("t4 rst map_rows", map_rows, 64'h0);
    dc0 = done_cnt;
    tick(10);
    check("t4 rst no done", done_cnt - dc0, 0);

    // 5/6: back-to-back maps 0 then 2 (bank 2 has a closed start cell)
    load = 1'b1; map_sel = 2'd0;          // T
    tick(1); map_sel = 2'd2;              // T+1
    tick(12);                             // T+13
    check("t5 first done", done, 1);
    check("t5 first rom_sel", rom_sel, 0);
    tick(1);                              // T+14: IDLE, re-trigger
    check("t5 idle gap", busy, 0);
    tick(1);                              // T+15
    check("t5 second busy", busy, 1);
    check("t5 second rom_sel", rom_sel, 2);
    load = 1'b0;
    tick(12);                             // T+27 = T'+13
    check("t6 done", done, 1);
    check("t6 err", err, CHECK_EN ? 1 : 0);
    check("t6 map_valid", map_valid, CHECK_EN ? 0 : 1);
    check("t6 start_pos readable", start_pos, 6'o23);
    tick(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
